elgamal_c2_stage: RTL and testbench
===================================

Name: elgamal_c2_stage

Overview:
Downstream consumer of two mod_exp instances in the ElGamal encryption path.
- Takes c1 = g^k mod p from one instance and the shared secret s = y^k mod p from the other, plus the plaintext m and the modulus p.
- Computes c2 = m*s mod p with an internal bit-serial interleaved modular multiplier.
- Emits the ciphertext as a 2-beat AXI stream: c1, then c2 with tlast.

Parameters:
SIZE, 64, operand/modulus width in bits (>= 2)

Ports:
clk  input  1  system clock, single clock domain
rst  input  1  asynchronous, active-low reset (asserted at 0)
c1_tdata  input  SIZE  c1 from g^k mod_exp
c1_tvalid  input  1  c1 valid
c1_tready  output  1  c1 accepted
secret_tdata  input  SIZE  s from y^k mod_exp
secret_tvalid  input  1  s valid
secret_tready  output  1  s accepted
msg_tdata  input  SIZE  plaintext m
msg_tvalid  input  1  m valid
msg_tready  output  1  m accepted
modulus_tdata  input  SIZE  modulus p
modulus_tvalid  input  1  p valid
modulus_tready  output  1  p accepted
output_tdata  output  SIZE  ciphertext beat
output_tvalid  output  1  beat valid
output_tlast  output  1  high on c2 beat
output_tready  input  1  downstream accepts beat

Behaviour:
- Reset (rst=0, async):
  - state=IDLE.
  - All tready=0, output_tvalid=0, output_tlast=0, output_tdata=0.
  - Internal registers cleared.
- States: IDLE -> MULT -> OUT_C1 -> OUT_C2 -> IDLE.
- IDLE, input acceptance:
  - all_valid = c1_tvalid & secret_tvalid & msg_tvalid & modulus_tvalid.
  - All four tready = (state==IDLE) & all_valid, so all four inputs are accepted in the same cycle or not at all.
  - A partial valid set is never consumed.
  - On accept: latch c1, s, m, p; acc=0; bit index i=SIZE-1; go to MULT.
- MULT: one multiplier bit per cycle, MSB first, exactly SIZE cycles.
  - d = {acc,1'b0} (SIZE+1 bits); if d >= p then d = d - p.
  - If m[i]: t = d + s (SIZE+1 bits); if t >= p then t = t - p; else t = d.
  - acc <= t[SIZE-1:0]; i decrements.
  - After the i=0 step, go to OUT_C1.
- Operand precondition: m < p, s < p, p >= 2. Result is undefined otherwise (see optional feature).
- Latency: accept on cycle N; output_tvalid rises on cycle N+SIZE+1.
- OUT_C1:
  - output_tdata = c1, output_tvalid = 1, output_tlast = 0.
  - Held stable until output_tready; the handshake moves to OUT_C2.
- OUT_C2:
  - output_tdata = acc, output_tvalid = 1, output_tlast = 1.
  - Held until output_tready; the handshake moves to IDLE.
  - On the handshake cycle tready stays low; a new accept is possible on the following cycle at the earliest.
- Backpressure: output_tready may stay low indefinitely; data, valid and last must not change while valid=1 and ready=0.
- output_tready is ignored outside the OUT states.
- Reset mid-operation, in any state: immediate return to IDLE with the reset values above; the partial result is discarded and no beat is emitted.
- Inputs asserting tvalid during MULT/OUT are not accepted; tready stays 0.

Optional Feature:
Macro: ELGAMAL_RANGE_CHECK_EN
- Defined:
  - Adds output output_tuser (1 bit).
  - On accept, register err = (m >= p) | (s >= p) | (p < 2).
  - If err: skip the multiply and go straight to OUT_C1 with acc forced to 0.
  - output_tuser = err on both beats.
- Not defined: no output_tuser port, no checks; behaviour follows the precondition above.

Test Plan:
- SIZE=8, p=23, c1=9, m=5, s=7, all valid together, output_tready=1 -> beat0=9 (tlast=0) at accept+9 cycles, beat1=12 (tlast=1) on the next cycle.
- SIZE=8, p=251, m=250, s=250 -> c2=1. Then m=0, s=200 -> c2=0.
- SIZE=64, p=2^64-59, m=s=p-1 -> c2=1, valid at accept+65.
- Only c1/secret/msg valid, modulus_tvalid=0 for 20 cycles -> all tready stay 0. Raise modulus_tvalid -> single-cycle accept of all four.
- output_tready=0 for 10 cycles after valid -> beat0 stays 9, tvalid stays 1. Toggle ready -> exactly two beats, tlast only on the second.
- Assert rst=0 at MULT cycle 3 -> outputs 0 asynchronously. After release, a new transaction p=23, m=5, s=7 -> c2=12. With ELGAMAL_RANGE_CHECK_EN: m=30, p=23 -> c2=0 and tuser=1 on both beats.

Source files
------------

// File: rtl/elgamal_c2_stage.sv
// ElGamal c2 stage: c2 = m*s mod p via bit-serial interleaved multiply, then streams {c1, c2}.
// Optional ELGAMAL_RANGE_CHECK_EN adds output_tuser flagging out-of-range operands.
module elgamal_c2_stage #(
    parameter int SIZE = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SIZE-1:0] c1_tdata,
    input  logic            c1_tvalid,
    output logic            c1_tready,
    input  logic [SIZE-1:0] secret_tdata,
    input  logic            secret_tvalid,
    output logic            secret_tready,
    input  logic [SIZE-1:0] msg_tdata,
    input  logic            msg_tvalid,
    output logic            msg_tready,
    input  logic [SIZE-1:0] modulus_tdata,
    input  logic            modulus_tvalid,
    output logic            modulus_tready,
    output logic [SIZE-1:0] output_tdata,
    output logic            output_tvalid,
    output logic            output_tlast,
`ifdef ELGAMAL_RANGE_CHECK_EN
    output logic            output_tuser,
`endif
    input  logic            output_tready
);
    localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;

    typedef enum logic [1:0] {IDLE, MULT, OUT_C1, OUT_C2} state_t;

    state_t          state_q, state_d;
    logic [SIZE-1:0] c1_q, c1_d, s_q, s_d, m_q, m_d, p_q, p_d, acc_q, acc_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            accept, start_err;
    logic [SIZE:0]   d_ext, t_ext;

    assign accept = (state_q == IDLE) & c1_tvalid & secret_tvalid & msg_tvalid & modulus_tvalid;

`ifdef ELGAMAL_RANGE_CHECK_EN
    logic err_q, err_d;
    assign start_err = (msg_tdata >= modulus_tdata) | (secret_tdata >= modulus_tdata) |
                       (modulus_tdata < SIZE'(2));
    assign err_d     = accept ? start_err : err_q;
    assign output_tuser = ((state_q == OUT_C1) | (state_q == OUT_C2)) & err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_q <= 1'b0;
        else      err_q <= err_d;
    end
`else
    assign start_err = 1'b0;
`endif

    // One interleaved step: double-and-reduce, then conditionally add s and reduce.
    always_comb begin
        d_ext = {acc_q, 1'b0};
        if (d_ext >= {1'b0, p_q}) d_ext = d_ext - {1'b0, p_q};
        t_ext = d_ext;
        if (m_q[idx_q]) begin
            t_ext = d_ext + {1'b0, s_q};
            if (t_ext >= {1'b0, p_q}) t_ext = t_ext - {1'b0, p_q};
        end
    end

    always_comb begin
        state_d = state_q;
        c1_d    = c1_q;
        s_d     = s_q;
        m_d     = m_q;
        p_d     = p_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: if (accept) begin
                c1_d    = c1_tdata;
                s_d     = secret_tdata;
                m_d     = msg_tdata;
                p_d     = modulus_tdata;
                acc_d   = '0;
                idx_d   = IW'(SIZE - 1);
                state_d = start_err ? OUT_C1 : MULT;
            end
            MULT: begin
                acc_d = t_ext[SIZE-1:0];
                idx_d = idx_q - 1'b1;
                if (idx_q == '0) state_d = OUT_C1;
            end
            OUT_C1: if (output_tready) state_d = OUT_C2;
            OUT_C2: if (output_tready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            c1_q    <= '0;
            s_q     <= '0;
            m_q     <= '0;
            p_q     <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            c1_q    <= c1_d;
            s_q     <= s_d;
            m_q     <= m_d;
            p_q     <= p_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
        end
    end

    assign c1_tready      = accept;
    assign secret_tready  = accept;
    assign msg_tready     = accept;
    assign modulus_tready = accept;

    // Beats are decoded straight from state so they hold under backpressure and clear on reset.
    always_comb begin
        output_tdata  = '0;
        output_tvalid = 1'b0;
        output_tlast  = 1'b0;
        if (state_q == OUT_C1) begin
            output_tdata  = c1_q;
            output_tvalid = 1'b1;
        end else if (state_q == OUT_C2) begin
            output_tdata  = acc_q;
            output_tvalid = 1'b1;
            output_tlast  = 1'b1;
        end
    end
endmodule

// File: tb/tb_elgamal_c2_stage.sv
// Directed bench for elgamal_c2_stage: 8-bit and 64-bit instances, hand-computed results.
module tb_elgamal_c2_stage;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] c1, sec, msg, mdl, od;
    logic       v_c1, v_s, v_m, v_p, r_c1, r_s, r_m, r_p, ov, ol, ordy;
    logic [63:0] a_c1, a_sec, a_msg, a_mdl, a_od;
    logic        a_v, a_r_c1, a_r_s, a_r_m, a_r_p, a_ov, a_ol;
`ifdef ELGAMAL_RANGE_CHECK_EN
    logic tuser, a_tuser;
`endif

    elgamal_c2_stage #(.SIZE(8)) dut8 (
        .clk(clk), .rst(rst),
        .c1_tdata(c1), .c1_tvalid(v_c1), .c1_tready(r_c1),
        .secret_tdata(sec), .secret_tvalid(v_s), .secret_tready(r_s),
        .msg_tdata(msg), .msg_tvalid(v_m), .msg_tready(r_m),
        .modulus_tdata(mdl), .modulus_tvalid(v_p), .modulus_tready(r_p),
        .output_tdata(od), .output_tvalid(ov), .output_tlast(ol),
`ifdef ELGAMAL_RANGE_CHECK_EN
        .output_tuser(tuser),
`endif
        .output_tready(ordy));

    elgamal_c2_stage #(.SIZE(64)) dut64 (
        .clk(clk), .rst(rst),
        .c1_tdata(a_c1), .c1_tvalid(a_v), .c1_tready(a_r_c1),
        .secret_tdata(a_sec), .secret_tvalid(a_v), .secret_tready(a_r_s),
        .msg_tdata(a_msg), .msg_tvalid(a_v), .msg_tready(a_r_m),
        .modulus_tdata(a_mdl), .modulus_tvalid(a_v), .modulus_tready(a_r_p),
        .output_tdata(a_od), .output_tvalid(a_ov), .output_tlast(a_ol),
`ifdef ELGAMAL_RANGE_CHECK_EN
        .output_tuser(a_tuser),
`endif
        .output_tready(1'b1));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: present all four operands, confirm single-cycle accept,
    // keep valids up one more cycle to confirm nothing is re-accepted while busy.
    task automatic issue8(input string tag, input logic [7:0] c1v, sv, mv, pv);
        c1 = c1v; sec = sv; msg = mv; mdl = pv;
        v_c1 = 1'b1; v_s = 1'b1; v_m = 1'b1; v_p = 1'b1;
        #1 check({tag, "_accept"}, {r_c1, r_s, r_m, r_p}, 4'hF);
        @(negedge clk);
        check({tag, "_busy_rdy"}, {r_c1, r_s, r_m, r_p}, 4'h0);
        v_c1 = 1'b0; v_s = 1'b0; v_m = 1'b0; v_p = 1'b0;
    endtask

    // Starts one negedge after the accept edge; waits for beat 0 and drains both beats.
    task automatic collect8(input string tag, input logic [7:0] c1v, c2v, input int lat,
                            input logic uexp);
        int cnt;
        cnt  = 1;
        ordy = 1'b1;
        while (!ov && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check({tag, "_lat"}, 64'(cnt), 64'(lat));
        check({tag, "_b0"}, {ov, ol, od}, {2'b10, c1v});
`ifdef ELGAMAL_RANGE_CHECK_EN
        check({tag, "_u0"}, tuser, uexp);
`endif
        @(negedge clk);
        check({tag, "_b1"}, {ov, ol, od}, {2'b11, c2v});
`ifdef ELGAMAL_RANGE_CHECK_EN
        check({tag, "_u1"}, tuser, uexp);
`endif
        @(negedge clk);
        check({tag, "_idle"}, ov, 1'b0);
        ordy = 1'b0;
    endtask

    initial begin
        int cnt, beats;
        logic bad;
        logic [1:0] lasts;
        logic [7:0] b1;
        c1 = '0; sec = '0; msg = '0; mdl = '0; ordy = 1'b0;
        v_c1 = 1'b0; v_s = 1'b0; v_m = 1'b0; v_p = 1'b0;
        a_c1 = '0; a_sec = '0; a_msg = '0; a_mdl = '0; a_v = 1'b0;
        #12;
        check("rst_out", {ov, ol, od}, 10'h0);
        check("rst_out64", {a_ov, a_ol, a_od}, 66'h0);
        @(negedge clk);
        rst = 1'b1;

        // 5*7 mod 23 = 12
        @(negedge clk);
        issue8("t1", 8'd9, 8'd7, 8'd5, 8'd23);
        collect8("t1", 8'd9, 8'd12, 9, 1'b0);
        // 250*250 mod 251 = (-1)^2 = 1; 0*200 = 0
        issue8("t2", 8'd3, 8'd250, 8'd250, 8'd251);
        collect8("t2", 8'd3, 8'd1, 9, 1'b0);
        issue8("t3", 8'd4, 8'd200, 8'd0, 8'd251);
        collect8("t3", 8'd4, 8'd0, 9, 1'b0);

        // Partial valid set must never be consumed
        c1 = 8'd9; sec = 8'd7; msg = 8'd5; mdl = 8'd23;
        v_c1 = 1'b1; v_s = 1'b1; v_m = 1'b1; v_p = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bad |= r_c1 | r_s | r_m | r_p;
        end
        check("partial_rdy", bad, 1'b0);
        issue8("t4", 8'd9, 8'd7, 8'd5, 8'd23);
        collect8("t4", 8'd9, 8'd12, 9, 1'b0);

        // Backpressure: hold beat 0, then alternate ready
        issue8("bp", 8'd9, 8'd7, 8'd5, 8'd23);
        cnt = 1;
        while (!ov && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check("bp_lat", 64'(cnt), 64'd9);
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bad |= (od !== 8'd9) | (ov !== 1'b1) | (ol !== 1'b0);
            @(negedge clk);
        end
        check("bp_hold", bad, 1'b0);
        beats = 0; lasts = 2'b00; b1 = 8'h00;
        for (int i = 0; i < 8; i++) begin
            ordy = i[0];
            #1;
            if (ov && ordy) begin
                if (beats < 2) lasts[beats] = ol;
                if (beats == 1) b1 = od;
                beats++;
            end
            @(negedge clk);
        end
        ordy = 1'b0;
        check("bp_beats", 64'(beats), 64'd2);
        check("bp_lasts", lasts, 2'b10);
        check("bp_c2", b1, 8'd12);

        // Reset during MULT: outputs clear, partial result is dropped
        issue8("rm", 8'd9, 8'd7, 8'd5, 8'd23);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 check("rst_mult", {ov, ol, od, r_c1}, 11'h0);
        @(negedge clk);
        rst = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bad |= ov;
        end
        check("rst_nobeat", bad, 1'b0);

        // Asynchronous reset while beat 0 is held (sampled before the next posedge)
        issue8("ro", 8'd9, 8'd7, 8'd5, 8'd23);
        cnt = 1;
        while (!ov && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check("ro_valid", ov, 1'b1);
        #2 rst = 1'b0;
        #1 check("rst_async", {ov, ol, od}, 10'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        issue8("t5", 8'd9, 8'd7, 8'd5, 8'd23);
        collect8("t5", 8'd9, 8'd12, 9, 1'b0);

`ifdef ELGAMAL_RANGE_CHECK_EN
        // m >= p: multiply skipped, c2 forced to 0, error flagged on both beats
        issue8("rc", 8'd9, 8'd7, 8'd30, 8'd23);
        collect8("rc", 8'd9, 8'd0, 1, 1'b1);
`endif

        // 64-bit: p = 2^64-59, m = s = p-1 -> c2 = 1, valid at accept+65
        a_c1 = 64'h0123_4567_89AB_CDEF;
        a_mdl = 64'hFFFF_FFFF_FFFF_FFC5;
        a_msg = 64'hFFFF_FFFF_FFFF_FFC4;
        a_sec = 64'hFFFF_FFFF_FFFF_FFC4;
        a_v = 1'b1;
        #1 check("w_accept", {a_r_c1, a_r_s, a_r_m, a_r_p}, 4'hF);
        @(negedge clk);
        a_v = 1'b0;
        cnt = 1;
        while (!a_ov && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        check("w_lat", 64'(cnt), 64'd65);
        check("w_b0", a_od, 64'h0123_4567_89AB_CDEF);
        check("w_l0", a_ol, 1'b0);
        @(negedge clk);
        check("w_b1", a_od, 64'd1);
        check("w_l1", {a_ov, a_ol}, 2'b11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
